// File: rtl/and_gate_unit.sv
// Bitwise 2/3/4-input AND with combinational outputs and enable-loaded registered copies.
// q_valid marks that the registered copies hold a result loaded since the last reset.
module and_gate_unit #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] i_1,
   input  logic [WIDTH-1:0] i_2,
   input  logic [WIDTH-1:0] i_3,
   input  logic [WIDTH-1:0] i_4,
   output logic [WIDTH-1:0] o,
   output logic [WIDTH-1:0] o_3,
   output logic [WIDTH-1:0] o_4,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_3,
   output logic [WIDTH-1:0] q_4,
   output logic             q_valid
);

   generate
      if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
         $error("and_gate_unit: WIDTH must be in 1..64");
      end
   endgenerate

   // The wider products reuse the narrower ones so the AND tree is shared.
   assign o   = i_1 & i_2;
   assign o_3 = o & i_3;
   assign o_4 = o_3 & i_4;

   always_ff @(posedge clk) begin
      if (rst) begin
         q       <= '0;
         q_3     <= '0;
         q_4     <= '0;
         q_valid <= 1'b0;
      end else if (en) begin
         q       <= o;
         q_3     <= o_3;
         q_4     <= o_4;
         q_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_and_gate_unit.sv
// Directed bench for and_gate_unit: a 1-bit instance for the truth-table scenarios
// and an 8-bit instance for the wide-operand vector.
module tb_and_gate_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic       a_1 = 1'b0, a_2 = 1'b0, a_3 = 1'b0, a_4 = 1'b0;
   logic       a_o, a_o_3, a_o_4, a_q, a_q_3, a_q_4, a_q_valid;
   logic [7:0] w_1 = '0, w_2 = '0, w_3 = '0, w_4 = '0;
   logic [7:0] w_o, w_o_3, w_o_4, w_q, w_q_3, w_q_4;
   logic       w_q_valid;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   and_gate_unit #(.WIDTH(1)) u_narrow (
      .clk(clk), .rst(rst), .en(en),
      .i_1(a_1), .i_2(a_2), .i_3(a_3), .i_4(a_4),
      .o(a_o), .o_3(a_o_3), .o_4(a_o_4),
      .q(a_q), .q_3(a_q_3), .q_4(a_q_4), .q_valid(a_q_valid)
   );

   and_gate_unit #(.WIDTH(8)) u_wide (
      .clk(clk), .rst(rst), .en(en),
      .i_1(w_1), .i_2(w_2), .i_3(w_3), .i_4(w_4),
      .o(w_o), .o_3(w_o_3), .o_4(w_o_4),
      .q(w_q), .q_3(w_q_3), .q_4(w_q_4), .q_valid(w_q_valid)
   );

   // Advance one rising edge and settle 1 ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0;
      tick();
      n_vec++;
      if ({a_q, a_q_3, a_q_4, a_q_valid} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_narrow: got %b want 0000", {a_q, a_q_3, a_q_4, a_q_valid});
      end
      n_vec++;
      if ({w_q, w_q_3, w_q_4, w_q_valid} !== 25'd0) begin
         n_err++;
         $display("FAIL reset_wide: got %h/%h/%h/%b want 0/0/0/0", w_q, w_q_3, w_q_4, w_q_valid);
      end
      rst = 1'b0;
   endtask

   task automatic test_two_input();
      logic [1:0] vecs [5] = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b11};
      logic       exp  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         {a_1, a_2} = vecs[k];
         a_3 = 1'b0; a_4 = 1'b0;
         #1;
         n_vec++;
         if (a_o !== exp[k]) begin
            n_err++;
            $display("FAIL two_in_o[%0d]: got %b want %b", k, a_o, exp[k]);
         end
         tick();
         n_vec++;
         if (a_q !== exp[k] || a_q_valid !== 1'b1) begin
            n_err++;
            $display("FAIL two_in_q[%0d]: got q=%b v=%b want q=%b v=1", k, a_q, a_q_valid, exp[k]);
         end
      end
   endtask

   task automatic test_three_input();
      logic [2:0] v;
      logic       exp_o, exp_o3;
      en = 1'b1; a_4 = 1'b1;
      for (int k = 0; k < 8; k++) begin
         v = 3'(k);
         {a_1, a_2, a_3} = v;
         exp_o3 = (k == 7);
         exp_o  = (k >= 6);
         #1;
         n_vec++;
         if (a_o_3 !== exp_o3 || a_o !== exp_o) begin
            n_err++;
            $display("FAIL three_in_comb[%b]: got o=%b o_3=%b want o=%b o_3=%b", v, a_o, a_o_3, exp_o, exp_o3);
         end
         tick();
         n_vec++;
         if (a_q_3 !== exp_o3 || a_q !== exp_o) begin
            n_err++;
            $display("FAIL three_in_reg[%b]: got q=%b q_3=%b want q=%b q_3=%b", v, a_q, a_q_3, exp_o, exp_o3);
         end
      end
   endtask

   task automatic test_four_input();
      logic [3:0] v;
      logic       exp_o4;
      en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         v = 4'(k);
         {a_1, a_2, a_3, a_4} = v;
         exp_o4 = (k == 15);
         #1;
         n_vec++;
         if (a_o_4 !== exp_o4) begin
            n_err++;
            $display("FAIL four_in_o4[%b]: got %b want %b", v, a_o_4, exp_o4);
         end
         tick();
         n_vec++;
         if (a_q_4 !== exp_o4) begin
            n_err++;
            $display("FAIL four_in_q4[%b]: got %b want %b", v, a_q_4, exp_o4);
         end
      end
   endtask

   task automatic test_enable_hold();
      en = 1'b1; a_1 = 1'b1; a_2 = 1'b1;
      tick();
      n_vec++;
      if (a_q !== 1'b1) begin
         n_err++;
         $display("FAIL hold_load: got q=%b want 1", a_q);
      end
      en = 1'b0; a_1 = 1'b0;
      #1;
      n_vec++;
      if (a_o !== 1'b0) begin
         n_err++;
         $display("FAIL hold_o: got o=%b want 0", a_o);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_vec++;
         if (a_q !== 1'b1 || a_q_valid !== 1'b1) begin
            n_err++;
            $display("FAIL hold_q[%0d]: got q=%b v=%b want q=1 v=1", k, a_q, a_q_valid);
         end
      end
   endtask

   task automatic test_reset_priority();
      {a_1, a_2, a_3, a_4} = 4'b1111;
      en = 1'b1;
      tick();
      n_vec++;
      if (a_q_4 !== 1'b1) begin
         n_err++;
         $display("FAIL rstpri_preload: got q_4=%b want 1", a_q_4);
      end
      rst = 1'b1; en = 1'b1;
      tick();
      n_vec++;
      if ({a_q, a_q_3, a_q_4, a_q_valid} !== 4'b0000) begin
         n_err++;
         $display("FAIL rstpri_clear: got %b want 0000", {a_q, a_q_3, a_q_4, a_q_valid});
      end
      n_vec++;
      if (a_o_4 !== 1'b1) begin
         n_err++;
         $display("FAIL rstpri_o4: got %b want 1", a_o_4);
      end
      rst = 1'b0; en = 1'b0;
      tick();
      n_vec++;
      if (a_q_valid !== 1'b0 || a_q_4 !== 1'b0) begin
         n_err++;
         $display("FAIL rstpri_noload: got q_4=%b v=%b want 0 0", a_q_4, a_q_valid);
      end
      en = 1'b1;
      tick();
      n_vec++;
      if (a_q_4 !== 1'b1 || a_q_valid !== 1'b1) begin
         n_err++;
         $display("FAIL rstpri_reload: got q_4=%b v=%b want 1 1", a_q_4, a_q_valid);
      end
   endtask

   task automatic test_wide();
      en = 1'b0;
      w_1 = 8'hF0; w_2 = 8'hCC; w_3 = 8'hAA; w_4 = 8'hFF;
      #1;
      n_vec++;
      if (w_o !== 8'hC0 || w_o_3 !== 8'h80 || w_o_4 !== 8'h80) begin
         n_err++;
         $display("FAIL wide_comb: got %h/%h/%h want c0/80/80", w_o, w_o_3, w_o_4);
      end
      en = 1'b1;
      tick();
      n_vec++;
      if (w_q !== 8'hC0 || w_q_3 !== 8'h80 || w_q_4 !== 8'h80 || w_q_valid !== 1'b1) begin
         n_err++;
         $display("FAIL wide_reg: got %h/%h/%h v=%b want c0/80/80 v=1", w_q, w_q_3, w_q_4, w_q_valid);
      end
      // Inputs changing between edges must not reach the registers.
      w_1 = 8'h0F;
      #3;
      n_vec++;
      if (w_q !== 8'hC0 || w_o !== 8'h0C) begin
         n_err++;
         $display("FAIL wide_midcycle: got q=%h o=%h want q=c0 o=0c", w_q, w_o);
      end
      tick();
      n_vec++;
      if (w_q !== 8'h0C || w_q_3 !== 8'h08 || w_q_4 !== 8'h08) begin
         n_err++;
         $display("FAIL wide_reload: got %h/%h/%h want 0c/08/08", w_q, w_q_3, w_q_4);
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_two_input();
      test_three_input();
      test_four_input();
      test_enable_hold();
      test_reset_priority();
      test_wide();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/and_gate_unit.md
# and_gate_unit

Multi-width AND primitive unit providing 2-, 3- and 4-input bitwise AND. Each function has a combinational output and a registered output. It is the building block behind the team's and_gate / and3_gate / and4_gate functions. Downstream logic picks the combinational path for zero-latency use or the registered path for timing closure.

## Interface

Clocking is fixed: one clock, `clk`; reset `rst` is synchronous and active-high.

Parameters:
- `WIDTH`, default 1: bit width of every data input and output. Legal range is 1 to 64.

Ports:
- `clk`  input  1  the single clock; all registers update on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `en`  input  1  load enable for the registered outputs.
- `i_1`  input  WIDTH  operand 1.
- `i_2`  input  WIDTH  operand 2.
- `i_3`  input  WIDTH  operand 3.
- `i_4`  input  WIDTH  operand 4.
- `o`  output  WIDTH  combinational `i_1 & i_2`.
- `o_3`  output  WIDTH  combinational `i_1 & i_2 & i_3`.
- `o_4`  output  WIDTH  combinational `i_1 & i_2 & i_3 & i_4`.
- `q`  output  WIDTH  registered copy of `o`.
- `q_3`  output  WIDTH  registered copy of `o_3`.
- `q_4`  output  WIDTH  registered copy of `o_4`.
- `q_valid`  output  1  high when `q`, `q_3` and `q_4` hold a result loaded since the last reset.

## Operation

- All AND functions are bitwise: bit k of each output depends only on bit k of the inputs.
- `o`, `o_3` and `o_4` are pure combinational logic.
  - They do not depend on `clk`, `rst` or `en`.
  - They are valid even while `rst` is high.
- Unused operands are ignored; `i_3` and `i_4` have no effect on `o`.
- Registered path, evaluated at each rising edge of `clk`, in priority order:
  1. If `rst` = 1: `q`, `q_3`, `q_4` become all-zero and `q_valid` becomes 0.
  2. Else if `en` = 1: `q`, `q_3`, `q_4` load the current `o`, `o_3`, `o_4`, and `q_valid` becomes 1.
  3. Else: all registers hold their value.
- `q_valid` stays 1 until the next reset. `en` going low does not clear it.
- No state machine beyond the `q_valid` flag. No arithmetic; there is no carry or width growth.

## Timing

- Combinational path: zero cycles. `o`, `o_3`, `o_4` follow the inputs within the same cycle.
- Registered path: one cycle of latency. Inputs sampled at edge N with `en` = 1 appear on `q*` after edge N.
- Reset value of every registered output: `q` = `q_3` = `q_4` = 0 and `q_valid` = 0.
- Before the first reset edge, registered outputs are undefined. Benches must assert `rst` for at least one edge.
- Simultaneous `rst` and `en`: reset wins.
- Reset mid-stream: outputs clear on the reset edge. The first load afterwards needs `rst` = 0 and `en` = 1 at a later edge.
- Input changes between edges have no effect on `q*`.

## Test plan

- **2-input sequence.** WIDTH = 1, `en` = 1. Apply (`i_1`, `i_2`) = 11, 00, 10, 01, 11, one per 10 ns.
  - `o` must read 1, 0, 0, 0, 1.
  - `q` must show the same values one clock later.
- **3-input exhaustive.** Sweep (`i_1`, `i_2`, `i_3`) from 000 to 111 in binary order.
  - `o_3` = 1 only at 111.
  - `o` = 1 at 110 and 111.
- **4-input exhaustive.** Sweep all 16 combinations of (`i_1`..`i_4`).
  - `o_4` = 1 only when all four inputs are 1.
  - `q_4` mirrors `o_4` one cycle later.
- **Enable hold.** Load `i_1` = `i_2` = 1 with `en` = 1 so `q` = 1. Then drop `en` and set `i_1` = 0 for 3 cycles.
  - `q` must stay 1 and `q_valid` must stay 1.
  - `o` must go to 0 immediately.
- **Reset priority and mid-stream reset.** While `q_4` = 1, assert `rst` = 1 and `en` = 1 on the same edge.
  - After that edge: `q`, `q_3`, `q_4` = 0 and `q_valid` = 0.
  - `o_4` stays 1 while the inputs are all 1.
- **Wide operation.** WIDTH = 8, `i_1` = 0xF0, `i_2` = 0xCC, `i_3` = 0xAA, `i_4` = 0xFF.
  - Combinational: `o` = 0xC0, `o_3` = 0x80, `o_4` = 0x80.
  - The `q*` outputs show the same values after one enabled edge.
